// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// Also exports the reset fetch address used by the fetch stage.
package icache_pkg;

  localparam int DEF_ADDRESS_WIDTH  = 32;
  localparam int DEF_SETS           = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam int OFF_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDRESS_WIDTH - IDX_W - OFF_W - 2;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// master = cache (read initiator), slave = fetch stage plus instruction memory.
interface icache_fetch_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) ();

  logic                     fetch_en_i;
  logic [ADDRESS_WIDTH-1:0] pc_i;
  logic                     flush_i;
  logic [DATA_WIDTH-1:0]    instr_o;
  logic                     instr_valid_o;
  logic                     stall_o;
  logic                     mem_req_o;
  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic                     mem_rvalid_i;
  logic [DATA_WIDTH-1:0]    mem_rdata_i;

  modport master (
    input  fetch_en_i, pc_i, flush_i, mem_rvalid_i, mem_rdata_i,
    output instr_o, instr_valid_o, stall_o, mem_req_o, mem_addr_o
  );

  modport slave (
    output fetch_en_i, pc_i, flush_i, mem_rvalid_i, mem_rdata_i,
    input  instr_o, instr_valid_o, stall_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped cache: hit compare, line validate, clear-all.
// Only the valid bits are reset; tags are meaningless while their line is invalid.
module icache_tag_array #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clear_all
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];

  // Clear-all wins over a same-cycle validate so an aborted refill never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_q[set_idx] <= set_tag;
    end
  end

  assign hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: zero-latency hit path, line refill one word per beat.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
//
// state  | meaning
// IDLE   | lookup; hit served combinationally, miss with no flush starts a refill
// REFILL | requesting line words from memory, pipeline stalled
module icache_fetch
  import icache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  icache_fetch_if.master bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]    hit_cnt_o,
  output logic [31:0]    miss_cnt_o
`endif
);

  localparam int OFF_B = $clog2(WORDS_PER_LINE);
  localparam int IDX_B = $clog2(SETS);
  localparam int TAG_B = ADDRESS_WIDTH - IDX_B - OFF_B - 2;

  state_t                  state_q;
  logic [OFF_B-1:0]        beat_q;
  logic                    abort_q;
  logic [TAG_B-1:0]        ref_tag_q;
  logic [IDX_B-1:0]        ref_idx_q;
  logic [DATA_WIDTH-1:0]   data_q [SETS][WORDS_PER_LINE];

  logic [TAG_B-1:0]        pc_tag;
  logic [IDX_B-1:0]        pc_idx;
  logic [OFF_B-1:0]        pc_word;
  logic                    unused_byte_off;
  logic                    tag_hit;
  logic                    in_idle;
  logic                    hit;
  logic                    start_refill;
  logic                    beat_ok;
  logic                    last_beat;
  logic                    set_en;

  assign pc_tag          = bus.pc_i[ADDRESS_WIDTH-1 -: TAG_B];
  assign pc_idx          = bus.pc_i[OFF_B+2 +: IDX_B];
  assign pc_word         = bus.pc_i[2 +: OFF_B];
  assign unused_byte_off = ^bus.pc_i[1:0];

  assign in_idle      = (state_q == IDLE);
  assign hit          = rst_n & in_idle & bus.fetch_en_i & ~bus.flush_i & tag_hit;
  assign start_refill = in_idle & bus.fetch_en_i & ~bus.flush_i & ~tag_hit;
  assign beat_ok      = ~in_idle & bus.mem_rvalid_i;
  assign last_beat    = (beat_q == OFF_B'(WORDS_PER_LINE - 1));
  assign set_en       = beat_ok & last_beat & ~abort_q & ~bus.flush_i;

  icache_tag_array #(
    .SETS  (SETS),
    .IDX_W (IDX_B),
    .TAG_W (TAG_B)
  ) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_idx (pc_idx),
    .lookup_tag (pc_tag),
    .hit        (tag_hit),
    .set_en     (set_en),
    .set_idx    (ref_idx_q),
    .set_tag    (ref_tag_q),
    .clear_all  (bus.flush_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_refill) begin
            state_q <= REFILL;
            beat_q  <= '0;
            abort_q <= 1'b0;
          end
        end
        REFILL: begin
          if (bus.flush_i) begin
            abort_q <= 1'b1;
          end
          if (bus.mem_rvalid_i) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              state_q <= IDLE;
              abort_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line address and data storage carry no reset; only valid bits gate their use.
  always_ff @(posedge clk) begin
    if (start_refill) begin
      ref_tag_q <= pc_tag;
      ref_idx_q <= pc_idx;
    end
    if (beat_ok) begin
      data_q[ref_idx_q][beat_q] <= bus.mem_rdata_i;
    end
  end

  assign bus.instr_valid_o = hit;
  assign bus.instr_o       = hit ? data_q[pc_idx][pc_word] : '0;
  assign bus.stall_o       = rst_n & (~in_idle | (bus.fetch_en_i & ~hit));
  assign bus.mem_req_o     = ~in_idle;
  assign bus.mem_addr_o    = in_idle ? '0 : {ref_tag_q, ref_idx_q, beat_q, 2'b00};

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (start_refill && (miss_cnt_o != 32'hFFFF_FFFF)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Randomized and directed bench for icache_fetch against a line-level cache model.
// Build with ICACHE_PERF_EN defined to also check the hit/miss counters.
module tb_icache_fetch;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_fetch_if bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: whole-line view of the cache keyed by (pc / 16) % 16 with tag pc / 256.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_data  [16][4];
  bit          m_busy;
  logic [31:0] m_base;
  int          m_got;
  bit          m_abort;
  logic [31:0] m_hits, m_miss;

  bit          cur_fe, cur_fl, cur_rv, e_hit;
  logic [31:0] cur_pc, cur_rd;
  logic        s_req, s_stall, s_iv;
  logic [31:0] s_addr, s_instr;

  int          w_cfg, wcnt;
  bit          rand_wait, idle_noise;
  logic [31:0] addr_q[$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] r;
    r = a ^ 32'hA5C3_0F96;
    r = {r[7:0], r[31:8]} + a;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0;
    m_got  = 0;
    m_abort = 1'b0;
    m_hits = '0;
    m_miss = '0;
  endtask

  task automatic compare();
    int          idx, w;
    logic        e_req, e_stall, e_iv;
    logic [31:0] e_addr, e_instr;
    idx = int'((cur_pc >> 4) % 32'd16);
    w   = int'((cur_pc >> 2) % 32'd4);
    e_hit = 1'b0;
    if (m_busy) begin
      e_req = 1'b1; e_addr = m_base + 32'(4 * m_got);
      e_stall = 1'b1; e_iv = 1'b0; e_instr = '0;
    end else begin
      e_hit = cur_fe && !cur_fl && m_valid[idx] && (m_tag[idx] == (cur_pc >> 8));
      e_req = 1'b0; e_addr = '0;
      e_iv = e_hit; e_stall = cur_fe && !e_hit;
      e_instr = e_hit ? m_data[idx][w] : '0;
    end
    s_req = bus.mem_req_o; s_addr = bus.mem_addr_o; s_stall = bus.stall_o;
    s_iv = bus.instr_valid_o; s_instr = bus.instr_o;
    check("mem_req", {31'd0, s_req}, {31'd0, e_req});
    check("mem_addr", s_addr, e_addr);
    check("stall", {31'd0, s_stall}, {31'd0, e_stall});
    check("instr_valid", {31'd0, s_iv}, {31'd0, e_iv});
    check("instr", s_instr, e_instr);
`ifdef ICACHE_PERF_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_miss);
`endif
  endtask

  task automatic model_update();
    int bidx;
    if (m_busy) begin
      bidx = int'((m_base >> 4) % 32'd16);
      if (cur_rv) begin
        m_data[bidx][m_got] = cur_rd;
        m_got++;
        if (m_got == 4) begin
          m_busy = 1'b0;
          if (!cur_fl && !m_abort) begin
            m_valid[bidx] = 1'b1;
            m_tag[bidx] = m_base >> 8;
          end
        end
      end
      if (cur_fl) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_abort = 1'b1;
      end
    end else begin
      if (e_hit && m_hits != 32'hFFFF_FFFF) m_hits++;
      if (cur_fl) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (cur_fe && !e_hit) begin
        m_busy = 1'b1; m_base = cur_pc & ~32'hF; m_got = 0; m_abort = 1'b0;
        if (m_miss != 32'hFFFF_FFFF) m_miss++;
      end
    end
  endtask

  // One clock: drive inputs and the memory response, compare, then advance the model.
  task automatic step(input bit fe, input logic [31:0] pc, input bit fl);
    @(negedge clk);
    cur_fe = fe; cur_pc = pc; cur_fl = fl;
    if (bus.mem_req_o) begin
      if (wcnt >= w_cfg) begin
        cur_rv = 1'b1; cur_rd = rom(bus.mem_addr_o); wcnt = 0;
        if (rand_wait) w_cfg = $urandom_range(0, 3);
      end else begin
        cur_rv = 1'b0; cur_rd = $urandom; wcnt++;
      end
    end else begin
      cur_rv = idle_noise && ($urandom_range(0, 3) == 0);
      cur_rd = $urandom; wcnt = 0;
    end
    bus.fetch_en_i = fe; bus.pc_i = pc; bus.flush_i = fl;
    bus.mem_rvalid_i = cur_rv; bus.mem_rdata_i = cur_rd;
    #1;
    compare();
    model_update();
  endtask

  task automatic run_until_hit(input logic [31:0] pc, output int reqs);
    bit got;
    reqs = 0; got = 1'b0;
    addr_q.delete();
    for (int k = 0; k < 200 && !got; k++) begin
      step(1'b1, pc, 1'b0);
      if (s_req) begin reqs++; addr_q.push_back(s_addr); end
      if (s_iv) got = 1'b1;
    end
    if (!got) check("hit_timeout", 32'd0, 32'd1);
  endtask

  localparam logic [31:0] P5 = 32'hBFC0_0080;
  localparam logic [31:0] P6 = 32'hBFC0_00C4;

  initial begin
    int reqs;
    bit flushed;
    logic [31:0] pool [4];
    logic [31:0] rpc;

    w_cfg = 0; wcnt = 0; rand_wait = 1'b0; idle_noise = 1'b0;
    rst_n = 1'b0;
    bus.fetch_en_i = 1'b1; bus.pc_i = RESET_PC; bus.flush_i = 1'b0;
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    model_reset();
    #1;
    check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    check("rst_instr_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_instr", bus.instr_o, 32'd0);
    bus.fetch_en_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Cold miss at the reset vector with a zero-latency memory.
    step(1'b1, RESET_PC, 1'b0);
    check("t1_miss_stall", {31'd0, s_stall}, 32'd1);
    check("t1_miss_no_req", {31'd0, s_req}, 32'd0);
    run_until_hit(RESET_PC, reqs);
    check("t1_refill_cycles", reqs, 32'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      check("t1_beat_addr", addr_q[i], 32'hBFC0_0000 + 32'(4 * i));
    check("t1_instr", s_instr, rom(32'hBFC0_0000));

    step(1'b1, 32'hBFC0_0008, 1'b0);
    check("t2_hit", {31'd0, s_iv}, 32'd1);
    check("t2_stall", {31'd0, s_stall}, 32'd0);
    check("t2_no_req", {31'd0, s_req}, 32'd0);
    check("t2_instr", s_instr, rom(32'hBFC0_0008));

    // Same index, different tag: mutual eviction.
    step(1'b1, 32'hBFC0_0100, 1'b0);
    check("t3_conflict_miss", {31'd0, s_iv}, 32'd0);
    run_until_hit(32'hBFC0_0100, reqs);
    check("t3_refill_base", addr_q.size() > 0 ? addr_q[0] : 32'hDEAD_BEEF, 32'hBFC0_0100);
    check("t3_instr", s_instr, rom(32'hBFC0_0100));
    step(1'b1, RESET_PC, 1'b0);
    check("t3_evicted_miss", {31'd0, s_iv}, 32'd0);
    run_until_hit(RESET_PC, reqs);

    // Three wait cycles per beat.
    w_cfg = 3;
    step(1'b1, 32'hBFC0_004C, 1'b0);
    run_until_hit(32'hBFC0_004C, reqs);
    check("t4_refill_cycles", reqs, 32'd16);
    check("t4_instr", s_instr, rom(32'hBFC0_004C));

    // Flush during beat 2: refill completes but the line stays invalid.
    w_cfg = 1; flushed = 1'b0;
    step(1'b1, P5, 1'b0);
    for (int k = 0; k < 100 && m_busy; k++) begin
      if (m_busy && m_got == 2 && !flushed) begin
        flushed = 1'b1;
        step(1'b1, P5, 1'b1);
      end else begin
        step(1'b1, P5, 1'b0);
      end
    end
    check("t5_flush_seen", {31'd0, flushed}, 32'd1);
    step(1'b1, P5, 1'b0);
    check("t5_refetch_miss", {31'd0, s_iv}, 32'd0);
    check("t5_refetch_stall", {31'd0, s_stall}, 32'd1);
    run_until_hit(P5, reqs);
    check("t5_refill_cycles", reqs, 32'd8);
    check("t5_instr", s_instr, rom(P5));

    // Reset in the middle of beat 1.
    w_cfg = 2;
    step(1'b1, P6, 1'b0);
    for (int k = 0; k < 50 && !(m_busy && m_got == 1); k++) step(1'b1, P6, 1'b0);
    step(1'b1, P6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("t6_rst_stall", {31'd0, bus.stall_o}, 32'd0);
    model_reset();
    bus.fetch_en_i = 1'b0; bus.mem_rvalid_i = 1'b0; wcnt = 0;
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, P6, 1'b0);
    check("t6_after_rst_miss", {31'd0, s_iv}, 32'd0);
    run_until_hit(P6, reqs);
    check("t6_refill_cycles", reqs, 32'd12);
    check("t6_instr", s_instr, rom(P6));

    // Random traffic over a few conflicting line groups.
    pool[0] = 32'hBFC0_0000; pool[1] = 32'hBFC0_0100;
    pool[2] = 32'hBFC0_0200; pool[3] = 32'h0000_1000;
    rand_wait = 1'b1; idle_noise = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      rpc = pool[$urandom_range(0, 3)] + 32'(16 * $urandom_range(0, 3))
            + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
